// File: rtl/apb_pkg.sv
// Shared APB definitions: master FSM states, default bus widths and the
// depth of the 32-word APB RAM that sits behind the master.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam int APB_AW    = 32;
  localparam int APB_DW    = 32;
  localparam int RAM_DEPTH = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: returns the first requesting client
// found when searching upward from last+1 with wrap, as a one-hot grant
// and as a binary index. The pointer register lives in the caller.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int LW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [LW-1:0]   last,
  output logic [NREQ-1:0] grant,
  output logic [LW-1:0]   idx
);

  logic [LW-1:0] cand;
  logic          found;

  // Walk the clients in priority order starting just after the last winner.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = LW'((int'(last) + k) % NREQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/apb_rr_master.sv
// Round-robin APB master: shares one APB slave between NREQ clients,
// sequences SETUP/ACCESS, and returns read data / error to the winner.
// A saturating watchdog bounds every ACCESS phase.
//
// Client handshake: a client raises req_valid with stable write/addr/wdata
// and holds them until the cycle in which its req_ready bit pulses; that
// pulse is the accept. Exactly one rsp_valid pulse later reports the result
// on the shared rsp_rdata/rsp_err, which are meaningful only in that cycle.
module apb_rr_master import apb_pkg::*; #(
  parameter int NREQ    = 4,
  parameter int AW      = APB_AW,
  parameter int DW      = APB_DW,
  parameter int TIMEOUT = 16
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_rdata,
  output logic               rsp_err,
  output logic               psel,
  output logic               penable,
  output logic               pwrite,
  output logic [AW-1:0]      paddr,
  output logic [DW-1:0]      pwdata,
  input  logic [DW-1:0]      prdata,
  input  logic               pready,
  input  logic               pslverr
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // With the watchdog disabled a 1-bit counter keeps the logic legal.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_TMO = CW'(TIMEOUT);

  apb_state_t      state;
  logic [LW-1:0]   last;
  logic [NREQ-1:0] gnt_oh;
  logic [CW-1:0]   wdog;

  logic [NREQ-1:0] arb_grant;
  logic [LW-1:0]   arb_idx;
  logic            timeout_hit;

  rr_arbiter #(
    .NREQ (NREQ),
    .LW   (LW)
  ) u_arb (
    .req   (req_valid),
    .last  (last),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  // pready has priority over the watchdog, so this is only consulted when
  // the slave has not answered.
  assign timeout_hit = (TIMEOUT != 0) && (wdog == CNT_TMO);

  // Master FSM: all bus and client outputs are registered here.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state     <= IDLE;
      last      <= LW'(NREQ - 1);
      gnt_oh    <= '0;
      wdog      <= '0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          if (|arb_grant) begin
            pwrite    <= req_write[arb_idx];
            paddr     <= req_addr[int'(arb_idx)*AW +: AW];
            pwdata    <= req_wdata[int'(arb_idx)*DW +: DW];
            req_ready <= arb_grant;
            gnt_oh    <= arb_grant;
            last      <= arb_idx;
            psel      <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          wdog    <= '0;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            rsp_valid <= gnt_oh;
            rsp_rdata <= pwrite ? '0 : prdata;
            rsp_err   <= pslverr;
            psel      <= 1'b0;
            penable   <= 1'b0;
            state     <= IDLE;
          end else if (timeout_hit) begin
            rsp_valid <= gnt_oh;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            psel      <= 1'b0;
            penable   <= 1'b0;
            state     <= IDLE;
          end else if (wdog != CNT_MAX) begin
            wdog <= wdog + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rr_master.sv
// Bench for apb_rr_master: a behavioural APB RAM slave, a scoreboard that
// predicts grant order, response contents and latency from the transfer
// rules, a table of directed transfers, hand-written corner sequences and
// a randomized phase.
module tb_apb_rr_master;
  import apb_pkg::*;

  localparam int NREQ    = 4;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;

  logic               pclk;
  logic               presetn;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_rdata;
  logic               rsp_err;
  logic               psel;
  logic               penable;
  logic               pwrite;
  logic [AW-1:0]      paddr;
  logic [DW-1:0]      pwdata;
  logic [DW-1:0]      prdata;
  logic               pready;
  logic               pslverr;

  apb_rr_master #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)
  ) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  // ---------------- clock ----------------
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // ---------------- reference model state ----------------
  int            cyc = 0;
  int            prio_q[$];          // clients in current priority order
  logic [DW-1:0] model_mem[RAM_DEPTH];
  logic [DW-1:0] slave_mem[RAM_DEPTH];
  logic [DW:0]   exp_q[$];           // {err, rdata}
  int            exp_cli_q[$];
  int            exp_lat_q[$];
  int            grant_log[$];
  bit            busy;
  int            grant_cyc;
  bit            cur_write;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_wdata;
  int            cur_waits;
  bit            cur_hang;
  logic [DW-1:0] cur_junk;
  int            acc_cnt;
  int            rsp_cnt = 0;
  int            got_cli;
  logic [DW-1:0] got_rdata;
  logic          got_err;
  int            got_cyc;
  // slave configuration
  int            cfg_waits = 0;
  bit            cfg_hang  = 0;
  bit            rand_slave = 0;
  bit            noise = 0;

  task automatic reset_model();
    prio_q.delete();
    for (int i = 0; i < NREQ; i++) prio_q.push_back(i);
    exp_q.delete();
    exp_cli_q.delete();
    exp_lat_q.delete();
    busy = 1'b0;
  endtask

  function automatic int model_pick();
    foreach (prio_q[k]) if (req_valid[prio_q[k]]) return prio_q[k];
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input bit w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_write[i]           = w;
    req_addr[i*AW +: AW]   = a;
    req_wdata[i*DW +: DW]  = d;
    req_valid[i]           = 1'b1;
  endtask

  // One clock: sample at the falling edge, score, then drive the slave.
  task automatic tick();
    bit          pend;
    int          g;
    int          f;
    int          lat;
    bit          in_rng;
    logic [DW:0] e;
    pend = (!busy && (req_valid != '0) && presetn);
    @(negedge pclk);
    cyc++;
    check("req_ready_vs_pending", 64'(req_ready != '0), 64'(pend));
    if (req_ready != '0) begin
      g = model_pick();
      if (g < 0) begin
        check("grant_without_request", 64'(req_ready), 64'(0));
      end else begin
        check("grant_onehot", 64'(req_ready), 64'(1) << g);
        while (prio_q[$] != g) begin
          f = prio_q.pop_front();
          prio_q.push_back(f);
        end
        cur_write = req_write[g];
        cur_addr  = req_addr[g*AW +: AW];
        cur_wdata = req_wdata[g*DW +: DW];
        check("setup_paddr", 64'(paddr), 64'(cur_addr));
        check("setup_pwrite", 64'(pwrite), 64'(cur_write));
        check("setup_pwdata", 64'(pwdata), 64'(cur_wdata));
        check("setup_psel", 64'(psel), 64'(1));
        check("setup_penable", 64'(penable), 64'(0));
        cur_waits = rand_slave ? int'($urandom_range(0, 3)) : cfg_waits;
        cur_hang  = rand_slave ? ($urandom_range(0, 19) == 0) : cfg_hang;
        cur_junk  = rand_slave ? DW'($urandom) : '0;
        in_rng    = (cur_addr < RAM_DEPTH);
        if (cur_hang) begin
          e   = {1'b1, {DW{1'b0}}};
          lat = TIMEOUT + 2;
        end else begin
          lat = cur_waits + 2;
          if (cur_write) begin
            e = {!in_rng, {DW{1'b0}}};
            if (in_rng) model_mem[cur_addr[4:0]] = cur_wdata;
          end else begin
            e = {!in_rng, in_rng ? model_mem[cur_addr[4:0]] : cur_junk};
          end
        end
        exp_q.push_back(e);
        exp_cli_q.push_back(g);
        exp_lat_q.push_back(lat);
        grant_log.push_back(g);
        req_valid[g] = 1'b0;
        busy      = 1'b1;
        grant_cyc = cyc;
        acc_cnt   = 0;
      end
    end
    if (rsp_valid != '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 64'(rsp_valid), 64'(0));
      end else begin
        e   = exp_q.pop_front();
        g   = exp_cli_q.pop_front();
        lat = exp_lat_q.pop_front();
        check("rsp_client", 64'(rsp_valid), 64'(1) << g);
        check("rsp_rdata", 64'(rsp_rdata), 64'(e[DW-1:0]));
        check("rsp_err", 64'(rsp_err), 64'(e[DW]));
        check("rsp_latency", 64'(cyc - grant_cyc), 64'(lat));
        check("rsp_psel", 64'(psel), 64'(0));
        check("rsp_penable", 64'(penable), 64'(0));
        got_cli   = g;
        got_rdata = rsp_rdata;
        got_err   = rsp_err;
        got_cyc   = cyc;
        rsp_cnt++;
        busy = 1'b0;
      end
    end else if (busy && req_ready == '0) begin
      check("access_psel", 64'(psel), 64'(1));
      check("access_penable", 64'(penable), 64'(1));
      check("access_paddr_stable", 64'(paddr), 64'(cur_addr));
      check("access_pwrite_stable", 64'(pwrite), 64'(cur_write));
      check("access_pwdata_stable", 64'(pwdata), 64'(cur_wdata));
    end else if (!busy) begin
      check("idle_psel", 64'(psel), 64'(0));
      check("idle_penable", 64'(penable), 64'(0));
    end
    // Slave: answer during ACCESS, otherwise optional noise that must be ignored.
    if (busy && req_ready == '0 && presetn) begin
      if (!cur_hang && acc_cnt == cur_waits) begin
        pready  = 1'b1;
        pslverr = !(paddr < RAM_DEPTH);
        if (pwrite) begin
          prdata = DW'($urandom);
          if (paddr < RAM_DEPTH) slave_mem[paddr[4:0]] = pwdata;
        end else begin
          prdata = (paddr < RAM_DEPTH) ? slave_mem[paddr[4:0]] : cur_junk;
        end
      end else begin
        pready  = 1'b0;
        pslverr = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        prdata  = DW'($urandom);
      end
      acc_cnt++;
    end else begin
      pready  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      pslverr = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      prdata  = DW'($urandom);
    end
  endtask

  task automatic wait_rsp(input int target, input int budget);
    int i;
    i = 0;
    while (rsp_cnt < target && i < budget) begin
      tick();
      i++;
    end
    if (rsp_cnt < target) begin
      total++;
      bad++;
      $display("FAIL wait_rsp: got %0d responses expected %0d within %0d cycles",
               rsp_cnt, target, budget);
    end
  endtask

  task automatic do_reset();
    presetn   = 1'b0;
    req_valid = '0;
    reset_model();
    tick();
    tick();
    presetn = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int            cli;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            waits;
    bit            hang;
    logic [DW-1:0] exp_rdata;
    bit            exp_err;
    int            exp_lat;
  } vec_t;

  vec_t vecs[10];

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int start;
    presetn   = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    for (int i = 0; i < RAM_DEPTH; i++) begin
      model_mem[i] = '0;
      slave_mem[i] = '0;
    end
    reset_model();

    // Reset values, observed before any clock edge.
    #3 presetn = 1'b0;
    #1;
    check("reset_psel", 64'(psel), 64'(0));
    check("reset_penable", 64'(penable), 64'(0));
    check("reset_pwrite", 64'(pwrite), 64'(0));
    check("reset_paddr", 64'(paddr), 64'(0));
    check("reset_pwdata", 64'(pwdata), 64'(0));
    check("reset_req_ready", 64'(req_ready), 64'(0));
    check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    check("reset_rsp_rdata", 64'(rsp_rdata), 64'(0));
    check("reset_rsp_err", 64'(rsp_err), 64'(0));
    tick();
    tick();
    presetn = 1'b1;

    //          cli wr addr  wdata         waits hang exp_rdata     err lat
    vecs[0] = '{0, 1, 5,  32'hDEADBEEF, 0, 0, 32'h0,        0, 3};
    vecs[1] = '{0, 0, 5,  32'h0,        0, 0, 32'hDEADBEEF, 0, 3};
    vecs[2] = '{2, 0, 40, 32'h0,        0, 0, 32'h0,        1, 3};
    vecs[3] = '{1, 1, 7,  32'h12345678, 3, 0, 32'h0,        0, 6};
    vecs[4] = '{3, 0, 7,  32'h0,        1, 0, 32'h12345678, 0, 4};
    vecs[5] = '{2, 1, 31, 32'hA5A5F00F, 2, 0, 32'h0,        0, 5};
    vecs[6] = '{1, 0, 31, 32'h0,        0, 0, 32'hA5A5F00F, 0, 3};
    vecs[7] = '{3, 1, 32, 32'h0BADF00D, 0, 0, 32'h0,        1, 3};
    vecs[8] = '{0, 0, 0,  32'h0,        0, 1, 32'h0,        1, 19};
    vecs[9] = '{1, 0, 5,  32'h0,        0, 0, 32'hDEADBEEF, 0, 3};

    noise = 1'b1;
    foreach (vecs[v]) begin
      cfg_waits = vecs[v].waits;
      cfg_hang  = vecs[v].hang;
      n     = rsp_cnt;
      start = cyc;
      set_req(vecs[v].cli, vecs[v].wr, vecs[v].addr, vecs[v].wdata);
      wait_rsp(n + 1, 40);
      if (rsp_cnt > n) begin
        check($sformatf("vec%0d_client", v), 64'(got_cli), 64'(vecs[v].cli));
        check($sformatf("vec%0d_rdata", v), 64'(got_rdata), 64'(vecs[v].exp_rdata));
        check($sformatf("vec%0d_err", v), 64'(got_err), 64'(vecs[v].exp_err));
        check($sformatf("vec%0d_latency", v), 64'(got_cyc - start), 64'(vecs[v].exp_lat));
      end
    end
    cfg_hang  = 1'b0;
    cfg_waits = 0;

    // All four clients at once after reset: grants 0,1,2,3.
    do_reset();
    grant_log.delete();
    n = rsp_cnt;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, AW'(16 + i), '0);
    wait_rsp(n + NREQ, 60);
    check("rr_grant_count", 64'(grant_log.size()), 64'(NREQ));
    if (grant_log.size() == NREQ)
      for (int i = 0; i < NREQ; i++)
        check($sformatf("rr_order_%0d", i), 64'(grant_log[i]), 64'(i));

    // Reset during ACCESS: outputs drop without a clock edge, no response.
    cfg_hang = 1'b1;
    set_req(1, 1'b0, 32'd3, '0);
    tick();
    tick();
    tick();
    #2 presetn = 1'b0;
    #1;
    check("midreset_psel", 64'(psel), 64'(0));
    check("midreset_penable", 64'(penable), 64'(0));
    check("midreset_rsp_valid", 64'(rsp_valid), 64'(0));
    cfg_hang  = 1'b0;
    req_valid = '0;
    reset_model();
    tick();
    tick();
    presetn = 1'b1;
    grant_log.delete();
    n = rsp_cnt;
    set_req(1, 1'b0, 32'd9, '0);
    set_req(0, 1'b0, 32'd8, '0);
    wait_rsp(n + 2, 30);
    check("after_reset_count", 64'(grant_log.size()), 64'(2));
    if (grant_log.size() == 2) begin
      check("after_reset_first", 64'(grant_log[0]), 64'(0));
      check("after_reset_second", 64'(grant_log[1]), 64'(1));
    end

    // Randomized traffic with random wait states, hangs, withdrawals and bus noise.
    rand_slave = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(0, 3) == 0)
            set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 39)), DW'($urandom));
        end else if (busy && req_ready == '0 && $urandom_range(0, 30) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end
    begin
      int i;
      i = 0;
      while ((busy || req_valid != '0 || exp_q.size() != 0) && i < 400) begin
        tick();
        i++;
      end
      check("drain_idle", 64'(busy || req_valid != '0 || exp_q.size() != 0), 64'(0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
